mem_port_master: RTL and testbench

Initiator for the 16-byte DFF scratch RAM port (4-bit address, active-low `ce_n` read strobe, active-low `lr_n` write strobe, registered read data). It accepts single-byte and burst commands over a valid/ready command channel and drives the RAM strobes with correct cycle timing. Read data is returned over a valid/ready response channel with backpressure. It sits between on-chip control logic and the RAM macro, and both share `clk`, `rst_n` and `ena`.

---
 rtl/mem_port_master.sv | 112 +++++++++++
 tb/tb_mem_port_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Command-driven initiator for the DFF scratch RAM port: single and burst
// writes/reads, registered strobes, valid/ready response channel.
module mem_port_master #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [ADDR_BITS-1:0] cmd_len,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_ce_n,
  output logic                 mem_lr_n,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [ADDR_BITS-1:0] rsp_addr,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RSP} state_t;

  // One extra bit so a full 2^ADDR_BITS burst fits in the count.
  localparam int CW = ADDR_BITS + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cmd_cnt;

  assign cmd_ready = (state == IDLE) & ena;

  // op[1] selects the burst forms (FILL/DUMP); op[0] selects read direction.
  always_comb begin
    cmd_cnt = CW'(1);
    if (cmd_op[1]) cmd_cnt = CW'(cmd_len) + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ce_n  <= 1'b1;
      mem_lr_n  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      busy      <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_data;
            cnt       <= cmd_cnt;
            busy      <= 1'b1;
            if (cmd_op[0]) begin
              state    <= RD_ISSUE;
              mem_ce_n <= 1'b0;
            end else begin
              state    <= WR;
              mem_lr_n <= 1'b0;
            end
          end
        end
        WR: begin
          cnt      <= cnt - CW'(1);
          mem_addr <= mem_addr + ADDR_BITS'(1);
          if (cnt == CW'(1)) begin
            mem_lr_n <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
        RD_ISSUE: begin
          mem_ce_n <= 1'b1;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          rsp_data  <= mem_rdata;
          rsp_addr  <= mem_addr;
          rsp_valid <= 1'b1;
          cnt       <= cnt - CW'(1);
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cnt != '0) begin
              mem_addr <= mem_addr + ADDR_BITS'(1);
              mem_ce_n <= 1'b0;
              state    <= RD_ISSUE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a behavioural registered-read RAM.
module tb_mem_port_master;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr, cmd_len, mem_addr, rsp_addr;
  logic [7:0] cmd_data, mem_wdata, mem_rdata, rsp_data;
  logic       mem_ce_n, mem_lr_n, rsp_valid, rsp_ready, busy;

  logic [7:0] ram [16] = '{default: 8'h00};
  int         wr_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  mem_port_master #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_lr_n(mem_lr_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM macro model: shares ena, writes on lr_n, registered read on ce_n.
  always @(posedge clk) begin
    if (ena) begin
      if (!mem_lr_n) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
      end
      if (!mem_ce_n) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] l,
                      input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = d;
    chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [31:0] r;
  logic [3:0]  wrap_a [4];
  int          wbase;

  initial begin
    wrap_a[0] = 4'd14; wrap_a[1] = 4'd15; wrap_a[2] = 4'd0; wrap_a[3] = 4'd1;

    // Reset with random inputs
    r = $urandom;
    rst_n = 1'b0;
    cmd_valid = r[0]; cmd_op = r[2:1]; cmd_addr = r[6:3]; cmd_len = r[10:7];
    cmd_data = r[18:11]; rsp_ready = r[19]; ena = r[20];
    #7;
    chk("rst_ce_n", 32'(mem_ce_n), 1);
    chk("rst_lr_n", 32'(mem_lr_n), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    cmd_valid = 1'b0; rsp_ready = 1'b0; ena = 1'b1;
    #5 rst_n = 1'b1;
    #1 chk("rel_cmd_ready", 32'(cmd_ready), 1);

    // Single WRITE addr 3 data A5
    tick();
    send(2'd0, 4'd3, 4'd0, 8'hA5);
    chk("wr_lr_n", 32'(mem_lr_n), 0);
    chk("wr_ce_n", 32'(mem_ce_n), 1);
    chk("wr_addr", 32'(mem_addr), 3);
    chk("wr_wdata", 32'(mem_wdata), 32'hA5);
    chk("wr_cmd_ready_low", 32'(cmd_ready), 0);
    tick();
    chk("wr_lr_n_done", 32'(mem_lr_n), 1);
    chk("wr_cmd_ready_again", 32'(cmd_ready), 1);
    chk("wr_ram3", 32'(ram[3]), 32'hA5);

    // Single READ addr 3: rsp_valid 2 cycles after acceptance
    send(2'd1, 4'd3, 4'd0, 8'h00);
    chk("rd_ce_n", 32'(mem_ce_n), 0);
    chk("rd_addr", 32'(mem_addr), 3);
    tick();
    chk("rd_ce_n_wait", 32'(mem_ce_n), 1);
    chk("rd_rsp_valid_early", 32'(rsp_valid), 0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
    chk("rd_rsp_addr", 32'(rsp_addr), 3);
    chk("rd_rsp_cmd_ready", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    tick();
    chk("rd_rsp_valid_drop", 32'(rsp_valid), 0);
    chk("rd_busy_done", 32'(busy), 0);

    // Wrapping FILL addr 14 len 3 data 5C
    send(2'd2, 4'd14, 4'd3, 8'h5C);
    for (int i = 0; i < 4; i++) begin
      chk("fill_lr_n", 32'(mem_lr_n), 0);
      chk("fill_addr", 32'(mem_addr), 32'(wrap_a[i]));
      tick();
    end
    chk("fill_lr_n_done", 32'(mem_lr_n), 1);
    chk("fill_cmd_ready", 32'(cmd_ready), 1);

    // Wrapping DUMP addr 14 len 3, rsp_ready tied high
    send(2'd3, 4'd14, 4'd3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      chk("dump_ce_n", 32'(mem_ce_n), 0);
      chk("dump_ce_addr", 32'(mem_addr), 32'(wrap_a[k]));
      tick();
      tick();
      chk("dump_rsp_valid", 32'(rsp_valid), 1);
      chk("dump_rsp_data", 32'(rsp_data), 32'h5C);
      chk("dump_rsp_addr", 32'(rsp_addr), 32'(wrap_a[k]));
      tick();
    end
    chk("dump_busy_done", 32'(busy), 0);
    chk("dump_ce_n_idle", 32'(mem_ce_n), 1);

    // Backpressure: DUMP addr 0 len 1 with rsp_ready low
    rsp_ready = 1'b0;
    send(2'd3, 4'd0, 4'd1, 8'h00);
    tick();
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_data", 32'(rsp_data), 32'h5C);
      chk("bp_hold_addr", 32'(rsp_addr), 0);
      chk("bp_ce_n_high", 32'(mem_ce_n), 1);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_valid_drop", 32'(rsp_valid), 0);
    chk("bp_second_ce_n", 32'(mem_ce_n), 0);
    chk("bp_second_addr", 32'(mem_addr), 1);
    tick();
    tick();
    chk("bp_second_rsp_addr", 32'(rsp_addr), 1);
    chk("bp_second_rsp_data", 32'(rsp_data), 32'h5C);
    tick();
    chk("bp_busy_done", 32'(busy), 0);

    // Enable freeze during second beat of FILL addr 6 len 3
    wbase = wr_cnt;
    send(2'd2, 4'd6, 4'd3, 8'h77);
    chk("frz_first_addr", 32'(mem_addr), 6);
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_lr_n", 32'(mem_lr_n), 0);
      chk("frz_addr", 32'(mem_addr), 7);
      chk("frz_wdata", 32'(mem_wdata), 32'h77);
      chk("frz_busy", 32'(busy), 1);
      chk("frz_cmd_ready", 32'(cmd_ready), 0);
    end
    ena = 1'b1;
    tick();
    chk("frz_resume_addr", 32'(mem_addr), 8);
    tick();
    chk("frz_resume_addr2", 32'(mem_addr), 9);
    tick();
    chk("frz_lr_n_done", 32'(mem_lr_n), 1);
    chk("frz_write_count", 32'(wr_cnt - wbase), 4);
    for (int a = 6; a < 10; a++) chk("frz_ram_written", 32'(ram[a]), 32'h77);
    chk("frz_ram5_untouched", 32'(ram[5]), 0);
    chk("frz_ram10_untouched", 32'(ram[10]), 0);

    // Mid-burst reset during RSP of a DUMP
    rsp_ready = 1'b0;
    send(2'd3, 4'd0, 4'd3, 8'h00);
    tick();
    tick();
    chk("mrst_rsp_valid_pre", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid_async", 32'(rsp_valid), 0);
    chk("mrst_busy_async", 32'(busy), 0);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    wbase = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_ce_n_idle", 32'(mem_ce_n), 1);
      chk("mrst_lr_n_idle", 32'(mem_lr_n), 1);
      chk("mrst_busy_idle", 32'(busy), 0);
    end
    chk("mrst_no_writes", 32'(wr_cnt - wbase), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
